sram_bist: RTL and testbench

Parametrised built-in self-test engine for the external asynchronous SRAM, sitting between top-level glue and the `sram` controller's request port. On `start` it runs a write pass over a programmable address range with a selectable data pattern, then a read-verify pass, counting mismatches and flagging pass/fail. It generalises the fixed 18-bit/16-bit write-then-read counter exerciser: width, range and pattern are configurable, and readback is checked in hardware.

---
 rtl/sram_bist.sv | 166 ++++++++++++++++
 tb/tb_sram_bist.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bist.sv
// sram_bist: write-then-read-verify self-test engine in front of the SRAM controller request port.
// Optional first-failure capture is built when SRAM_BIST_FAILCAP_EN is defined.
module sram_bist #(
  parameter int                    ADDR_WIDTH = 18,
  parameter int                    DATA_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] LAST_ADDR  = {ADDR_WIDTH{1'b1}},
  parameter int                    ERR_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  step_en,
  input  logic [1:0]            mode,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  read_phase,
  output logic [ERR_WIDTH-1:0]  err_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_exp,
  output logic [DATA_WIDTH-1:0] fail_got,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_write,
  output logic                  mem_write,
  output logic                  mem_read,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_data_read
);

  typedef enum logic [2:0] {
    IDLE, WR_ISSUE, WR_ACK, WR_CMPL, RD_ISSUE, RD_ACK, RD_CMPL, DONE
  } state_t;

  state_t                state;
  logic [1:0]            mode_q;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] cur_pat;
  logic                  mismatch;
  logic [ERR_WIDTH-1:0]  err_next;

  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [1:0] m,
                                                    input logic [ADDR_WIDTH-1:0] a);
    logic [DATA_WIDTH-1:0] p;
    logic [ADDR_WIDTH-1:0] na;
    na = ~a;
    p  = '0;
    case (m)
      2'd0:    p = DATA_WIDTH'(a);
      2'd1:    p = DATA_WIDTH'(na);
      // odd addresses get 0x55.., even addresses 0xAA..
      2'd2:    for (int i = 0; i < DATA_WIDTH; i++) p[i] = a[0] ^ i[0];
      default: p = '1;
    endcase
    return p;
  endfunction

  always_comb begin
    cur_pat  = pattern(mode_q, addr);
    mismatch = (state == RD_CMPL) && mem_ready && (mem_data_read != cur_pat);
    err_next = err_count;
    if (mismatch && (err_count != '1)) err_next = err_count + ERR_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      mode_q         <= '0;
      addr           <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      read_phase     <= 1'b0;
      err_count      <= '0;
      mem_address    <= '0;
      mem_data_write <= '0;
      mem_write      <= 1'b0;
      mem_read       <= 1'b0;
`ifdef SRAM_BIST_FAILCAP_EN
      fail_addr      <= '0;
      fail_exp       <= '0;
      fail_got       <= '0;
`endif
    end else begin
      mem_write <= 1'b0;
      mem_read  <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            mode_q     <= mode;
            addr       <= '0;
            err_count  <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            read_phase <= 1'b0;
`ifdef SRAM_BIST_FAILCAP_EN
            fail_addr  <= '0;
            fail_exp   <= '0;
            fail_got   <= '0;
`endif
            state      <= WR_ISSUE;
          end
        end
        WR_ISSUE: begin
          if (step_en && mem_ready) begin
            mem_address    <= addr;
            mem_data_write <= cur_pat;
            mem_write      <= 1'b1;
            state          <= WR_ACK;
          end
        end
        WR_ACK: if (!mem_ready) state <= WR_CMPL;
        WR_CMPL: begin
          if (mem_ready) begin
            if (addr == LAST_ADDR) begin
              addr       <= '0;
              read_phase <= 1'b1;
              state      <= RD_ISSUE;
            end else begin
              addr  <= addr + ADDR_WIDTH'(1);
              state <= WR_ISSUE;
            end
          end
        end
        RD_ISSUE: begin
          if (step_en && mem_ready) begin
            mem_address <= addr;
            mem_read    <= 1'b1;
            state       <= RD_ACK;
          end
        end
        RD_ACK: if (!mem_ready) state <= RD_CMPL;
        RD_CMPL: begin
          if (mem_ready) begin
            err_count <= err_next;
`ifdef SRAM_BIST_FAILCAP_EN
            // a saturating count never returns to zero, so zero marks "no failure yet"
            if (mismatch && (err_count == '0)) begin
              fail_addr <= addr;
              fail_exp  <= cur_pat;
              fail_got  <= mem_data_read;
            end
`endif
            if (addr == LAST_ADDR) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_next == '0);
              state <= DONE;
            end else begin
              addr  <= addr + ADDR_WIDTH'(1);
              state <= RD_ISSUE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef SRAM_BIST_FAILCAP_EN
  assign fail_addr = '0;
  assign fail_exp  = '0;
  assign fail_got  = '0;
`endif

endmodule

// File: tb/tb_sram_bist.sv
// Bench for sram_bist: behavioural SRAM with fault masks, pattern scoreboard and
// two DUT copies (wide and 3-bit error counters) running in lockstep.
module tb_sram_bist;
  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          step_en = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic          mem_ready = 1'b1;
  logic [DW-1:0] mem_data_read = '0;

  logic          busy, done, pass, read_phase, mem_write, mem_read;
  logic [7:0]    err_count;
  logic [AW-1:0] fail_addr, mem_address;
  logic [DW-1:0] fail_exp, fail_got, mem_data_write;

  logic          b_busy, b_done, b_pass, b_read_phase, b_mem_write, b_mem_read;
  logic [2:0]    b_err_count;
  logic [AW-1:0] b_fail_addr, b_mem_address;
  logic [DW-1:0] b_fail_exp, b_fail_got, b_mem_data_write;

  always #5 clk = ~clk;

  sram_bist #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ERR_WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .step_en(step_en), .mode(mode),
    .busy(busy), .done(done), .pass(pass), .read_phase(read_phase),
    .err_count(err_count), .fail_addr(fail_addr), .fail_exp(fail_exp), .fail_got(fail_got),
    .mem_address(mem_address), .mem_data_write(mem_data_write),
    .mem_write(mem_write), .mem_read(mem_read),
    .mem_ready(mem_ready), .mem_data_read(mem_data_read));

  sram_bist #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ERR_WIDTH(3)) dut_sat (
    .clk(clk), .reset_n(reset_n), .start(start), .step_en(step_en), .mode(mode),
    .busy(b_busy), .done(b_done), .pass(b_pass), .read_phase(b_read_phase),
    .err_count(b_err_count), .fail_addr(b_fail_addr), .fail_exp(b_fail_exp), .fail_got(b_fail_got),
    .mem_address(b_mem_address), .mem_data_write(b_mem_data_write),
    .mem_write(b_mem_write), .mem_read(b_mem_read),
    .mem_ready(mem_ready), .mem_data_read(mem_data_read));

  int errors = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Expected data for address a under pattern m (4-bit address, 8-bit data).
  function automatic int pat(input int m, input int a);
    case (m)
      0:       return a;
      1:       return 15 - a;
      2:       return (a % 2 == 1) ? 'h55 : 'hAA;
      default: return 'hFF;
    endcase
  endfunction

  // SRAM model: ready low for lat cycles per access, readback passes through fault masks.
  logic [DW-1:0] mem [16];
  logic [7:0]    and_mask = 8'hFF;
  logic [7:0]    xor_mask = 8'h00;
  bit            rand_lat = 1'b0;
  int            sram_cnt = 0;

  always @(posedge clk) begin
    if (sram_cnt > 0) begin
      sram_cnt <= sram_cnt - 1;
      if (sram_cnt == 1) mem_ready <= 1'b1;
    end else if (mem_write || mem_read) begin
      mem_ready <= 1'b0;
      sram_cnt  <= rand_lat ? int'($urandom_range(3, 1)) : 1;
      if (mem_write) mem[mem_address] <= mem_data_write;
      else mem_data_read <= (mem[mem_address] & and_mask) ^ xor_mask;
    end
  end

  int step_period = 1;
  int cyc = 0;
  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    step_en = (cyc % step_period) == 0;
  end

  // Request monitor: protocol rules and write/read address+data sequence.
  int cur_mode = 0;
  int wr_cnt = 0, rd_cnt = 0, wr_base = 0, rd_base = 0;
  int both_err = 0, pulse_err = 0, step_err = 0;
  bit prev_w = 0, prev_r = 0, prev_step = 0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (mem_write && mem_read) both_err <= both_err + 1;
      if ((mem_write && prev_w) || (mem_read && prev_r)) pulse_err <= pulse_err + 1;
      if (((mem_write && !prev_w) || (mem_read && !prev_r)) && !prev_step) step_err <= step_err + 1;
      if (mem_write && !prev_w) begin
        check_val("wr_addr", 32'(mem_address), 32'(wr_cnt - wr_base));
        check_val("wr_data", 32'(mem_data_write), 32'(pat(cur_mode, wr_cnt - wr_base)));
        wr_cnt <= wr_cnt + 1;
      end
      if (mem_read && !prev_r) begin
        check_val("rd_addr", 32'(mem_address), 32'(rd_cnt - rd_base));
        check_val("rd_phase", 32'(read_phase), 32'd1);
        rd_cnt <= rd_cnt + 1;
      end
    end
    prev_w    <= mem_write;
    prev_r    <= mem_read;
    prev_step <= step_en;
  end

  task automatic start_test(input int m);
    @(posedge clk);
    #1;
    cur_mode = m;
    wr_base  = wr_cnt;
    rd_base  = rd_cnt;
    mode     = 2'(m);
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    mode  = 2'(m + 1);
    check_val("busy_rise", 32'(busy), 32'd1);
    check_val("done_clr", 32'(done), 32'd0);
  endtask

  task automatic finish_test(input int m, input bit mid_start, input string tag);
    int n, exp_err, first, fexp, fgot, p, g;
    exp_err = 0; first = -1; fexp = 0; fgot = 0;
    for (int a = 0; a < 16; a++) begin
      p = pat(m, a);
      g = ((p & int'(and_mask)) ^ int'(xor_mask)) & 'hFF;
      if (g != p) begin
        exp_err++;
        if (first < 0) begin first = a; fexp = p; fgot = g; end
      end
    end
    if (mid_start) begin
      repeat (40) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    n = 0;
    while (!done && n < 6000) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "_timeout"}, 32'(n < 6000), 32'd1);
    check_val({tag, "_busy"}, 32'(busy), 32'd0);
    check_val({tag, "_pass"}, 32'(pass), 32'(exp_err == 0));
    check_val({tag, "_errs"}, 32'(err_count), 32'(exp_err));
    check_val({tag, "_errs_sat"}, 32'(b_err_count), 32'(exp_err > 7 ? 7 : exp_err));
    check_val({tag, "_nwr"}, 32'(wr_cnt - wr_base), 32'd16);
    check_val({tag, "_nrd"}, 32'(rd_cnt - rd_base), 32'd16);
`ifdef SRAM_BIST_FAILCAP_EN
    check_val({tag, "_faddr"}, 32'(fail_addr), 32'(first < 0 ? 0 : first));
    check_val({tag, "_fexp"}, 32'(fail_exp), 32'(fexp));
    check_val({tag, "_fgot"}, 32'(fail_got), 32'(fgot));
`else
    check_val({tag, "_fcap"}, {fail_addr, fail_exp, fail_got}, 32'd0);
`endif
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_outs", {busy, done, pass, read_phase, err_count, mem_write, mem_read}, 32'd0);
    check_val("rst_mem", {mem_address, mem_data_write}, 32'd0);
    reset_n = 1'b1;

    start_test(0);
    finish_test(0, 1'b0, "m0_clean");

    and_mask = 8'hF7;
    start_test(3);
    finish_test(3, 1'b0, "m3_stuck");
    and_mask = 8'hFF;

    step_period = 5;
    start_test(2);
    finish_test(2, 1'b0, "m2_step5");
    step_period = 1;

    xor_mask = 8'hFF;
    start_test(1);
    finish_test(1, 1'b0, "m1_allbad");
    xor_mask = 8'h00;

    start_test(0);
    finish_test(0, 1'b1, "m0_midstart");

    // Abort while the read of address 5 is outstanding.
    start_test(2);
    n = 0;
    while (!(mem_read && mem_address == AW'(5)) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_val("abort_found", 32'(n < 2000), 32'd1);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check_val("abort_outs", {busy, done, pass, read_phase, err_count, mem_write, mem_read}, 32'd0);
    check_val("abort_mem", {mem_address, mem_data_write}, 32'd0);
    check_val("abort_fcap", {fail_addr, fail_exp, fail_got}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    n = 0;
    while (!mem_ready && n < 20) begin
      @(posedge clk);
      n++;
    end
    start_test(2);
    finish_test(2, 1'b0, "after_abort");

    rand_lat = 1'b1;
    for (int r = 0; r < 4; r++) begin
      int m;
      m = int'($urandom_range(3, 0));
      and_mask = ($urandom_range(1, 0) == 1) ? 8'hFF : 8'($urandom);
      step_period = int'($urandom_range(4, 1));
      start_test(m);
      finish_test(m, 1'b0, $sformatf("rand%0d", r));
    end

    check_val("both_strobes", 32'(both_err), 32'd0);
    check_val("strobe_len", 32'(pulse_err), 32'd0);
    check_val("req_wo_step", 32'(step_err), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
